// File: rtl/game_flow_sequencer_if.sv
// Button inputs and phase/status outputs of the rhythm-game flow sequencer.
// The sequencer uses the master modport; screen/audio/game logic uses the slave.
interface game_flow_sequencer_if #(
    parameter int NUM_ROUNDS = 3,
    parameter int TIMER_W    = 40
);
    localparam int RW = $clog2(NUM_ROUNDS + 1);

    logic               start_n;
    logic               pause_n;
    logic               round_pass;
    logic [2:0]         state;
    logic               enable_title_screen;
    logic               enable_idle_screen;
    logic               enable_title_audio;
    logic               enable_countdown_screen;
    logic               enable_countdown_audio;
    logic               enable_song;
    logic               game_active;
    logic               show_pause_screen;
    logic               show_game_over;
    logic               game_won;
    logic [RW-1:0]      round_idx;
    logic [TIMER_W-1:0] phase_cycles;
    logic [7:0]         sec_remaining;
    logic               sec_tick;
    logic               state_changed;

    modport master (
        input  start_n, pause_n, round_pass,
        output state, enable_title_screen, enable_idle_screen, enable_title_audio,
               enable_countdown_screen, enable_countdown_audio, enable_song,
               game_active, show_pause_screen, show_game_over, game_won,
               round_idx, phase_cycles, sec_remaining, sec_tick, state_changed
    );

    modport slave (
        output start_n, pause_n, round_pass,
        input  state, enable_title_screen, enable_idle_screen, enable_title_audio,
               enable_countdown_screen, enable_countdown_audio, enable_song,
               game_active, show_pause_screen, show_game_over, game_won,
               round_idx, phase_cycles, sec_remaining, sec_tick, state_changed
    );
endinterface

// File: rtl/game_flow_sequencer.sv
// Multi-round game-flow controller: title, idle, countdown, play, pause, game over,
// with synchronised button presses and pause-frozen phase/second counters.
module game_flow_sequencer #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TITLE_SEC     = 32,
    parameter int COUNTDOWN_SEC = 5,
    parameter int SONG_SEC      = 64,
    parameter int NUM_ROUNDS    = 3,
    parameter int TIMER_W       = 40
) (
    input logic                   clock,
    input logic                   reset_n,
    game_flow_sequencer_if.master bus
);
    localparam int RW    = $clog2(NUM_ROUNDS + 1);
    localparam int SUB_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [TIMER_W-1:0] TITLE_LAST = TIMER_W'(64'(CLK_HZ) * 64'(TITLE_SEC) - 64'd1);
    localparam logic [TIMER_W-1:0] CD_LAST    = TIMER_W'(64'(CLK_HZ) * 64'(COUNTDOWN_SEC) - 64'd1);
    localparam logic [TIMER_W-1:0] SONG_LAST  = TIMER_W'(64'(CLK_HZ) * 64'(SONG_SEC) - 64'd1);
    localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(CLK_HZ - 1);
    localparam logic [RW-1:0]      LAST_ROUND = RW'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_IDLE      = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_PLAYING   = 3'd3,
        ST_PAUSE     = 3'd4,
        ST_GAMEOVER  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    state_e             saved_q, saved_d;
    logic [2:0]         start_sh_q, start_sh_d;
    logic [2:0]         pause_sh_q, pause_sh_d;
    logic [RW-1:0]      round_idx_q, round_idx_d;
    logic               game_won_q, game_won_d;
    logic [TIMER_W-1:0] phase_cycles_q, phase_cycles_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [7:0]         sec_remaining_q, sec_remaining_d;
    logic               sec_tick_q, sec_tick_d;
    logic               state_changed_q, state_changed_d;

    logic       start_press, pause_press;
    logic       timed, timeout, enter_pause, resume, clear, inc, wrap;
    logic [7:0] sec_load;

    // [0] = first synchroniser stage, [1] = synchronised level, [2] = previous level
    assign start_sh_d  = {start_sh_q[1:0], bus.start_n};
    assign pause_sh_d  = {pause_sh_q[1:0], bus.pause_n};
    assign start_press = start_sh_q[2] & ~start_sh_q[1];
    assign pause_press = pause_sh_q[2] & ~pause_sh_q[1];

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        round_idx_d = round_idx_q;
        game_won_d  = game_won_q;
        timed       = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            ST_STARTUP:   begin timed = 1'b1; timeout = (phase_cycles_q == TITLE_LAST); end
            ST_COUNTDOWN: begin timed = 1'b1; timeout = (phase_cycles_q == CD_LAST);    end
            ST_PLAYING:   begin timed = 1'b1; timeout = (phase_cycles_q == SONG_LAST);  end
            default:      ;
        endcase

        // A timeout always beats a press landing on the same cycle
        case (state_q)
            ST_STARTUP: begin
                if (timeout || start_press) state_d = ST_IDLE;
                else if (pause_press)       state_d = ST_PAUSE;
            end
            ST_IDLE: begin
                if (start_press) begin
                    state_d     = ST_COUNTDOWN;
                    round_idx_d = '0;
                    game_won_d  = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (timeout)          state_d = ST_PLAYING;
                else if (pause_press) state_d = ST_PAUSE;
            end
            ST_PLAYING: begin
                if (timeout) begin
                    if (!bus.round_pass) begin
                        state_d    = ST_GAMEOVER;
                        game_won_d = 1'b0;
                    end else if (round_idx_q < LAST_ROUND) begin
                        state_d     = ST_COUNTDOWN;
                        round_idx_d = round_idx_q + RW'(1);
                    end else begin
                        state_d    = ST_GAMEOVER;
                        game_won_d = 1'b1;
                    end
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE:    if (pause_press) state_d = saved_q;
            ST_GAMEOVER: if (start_press) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        enter_pause = (state_d == ST_PAUSE) && (state_q != ST_PAUSE);
        resume      = (state_q == ST_PAUSE) && (state_d != ST_PAUSE);
        if (enter_pause) saved_d = state_q;

        // Pause entry/exit keeps the phase counters so the phase resumes where it stopped
        clear = (state_d != state_q) && !enter_pause && !resume;
        inc   = timed && !clear;
        wrap  = (sub_q == SUB_LAST);

        case (state_d)
            ST_STARTUP:   sec_load = 8'(TITLE_SEC);
            ST_COUNTDOWN: sec_load = 8'(COUNTDOWN_SEC);
            ST_PLAYING:   sec_load = 8'(SONG_SEC);
            default:      sec_load = 8'd0;
        endcase

        phase_cycles_d  = clear ? '0 : (inc ? phase_cycles_q + TIMER_W'(1) : phase_cycles_q);
        sub_d           = clear ? '0 : (inc ? (wrap ? '0 : sub_q + SUB_W'(1)) : sub_q);
        sec_tick_d      = inc && wrap;
        sec_remaining_d = clear ? sec_load : (sec_tick_d ? sec_remaining_q - 8'd1 : sec_remaining_q);
        state_changed_d = (state_d != state_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_STARTUP;
            saved_q         <= ST_STARTUP;
            start_sh_q      <= 3'b111;
            pause_sh_q      <= 3'b111;
            round_idx_q     <= '0;
            game_won_q      <= 1'b0;
            phase_cycles_q  <= '0;
            sub_q           <= '0;
            sec_remaining_q <= 8'(TITLE_SEC);
            sec_tick_q      <= 1'b0;
            state_changed_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            saved_q         <= saved_d;
            start_sh_q      <= start_sh_d;
            pause_sh_q      <= pause_sh_d;
            round_idx_q     <= round_idx_d;
            game_won_q      <= game_won_d;
            phase_cycles_q  <= phase_cycles_d;
            sub_q           <= sub_d;
            sec_remaining_q <= sec_remaining_d;
            sec_tick_q      <= sec_tick_d;
            state_changed_q <= state_changed_d;
        end
    end

    // PAUSE keeps the interrupted phase's screen visible but silences audio and gameplay
    always_comb begin
        bus.enable_title_screen     = 1'b0;
        bus.enable_idle_screen      = 1'b0;
        bus.enable_title_audio      = 1'b0;
        bus.enable_countdown_screen = 1'b0;
        bus.enable_countdown_audio  = 1'b0;
        bus.enable_song             = 1'b0;
        bus.game_active             = 1'b0;
        bus.show_pause_screen       = 1'b0;
        bus.show_game_over          = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                bus.enable_title_screen = 1'b1;
                bus.enable_title_audio  = 1'b1;
            end
            ST_IDLE: bus.enable_idle_screen = 1'b1;
            ST_COUNTDOWN: begin
                bus.enable_countdown_screen = 1'b1;
                bus.enable_countdown_audio  = 1'b1;
            end
            ST_PLAYING: begin
                bus.enable_song = 1'b1;
                bus.game_active = 1'b1;
            end
            ST_PAUSE: begin
                bus.show_pause_screen       = 1'b1;
                bus.enable_title_screen     = (saved_q == ST_STARTUP);
                bus.enable_countdown_screen = (saved_q == ST_COUNTDOWN);
            end
            ST_GAMEOVER: bus.show_game_over = 1'b1;
            default: ;
        endcase
    end

    assign bus.state         = state_q;
    assign bus.round_idx     = round_idx_q;
    assign bus.game_won      = game_won_q;
    assign bus.phase_cycles  = phase_cycles_q;
    assign bus.sec_remaining = sec_remaining_q;
    assign bus.sec_tick      = sec_tick_q;
    assign bus.state_changed = state_changed_q;
endmodule

// File: tb/tb_game_flow_sequencer.sv
// Bench for game_flow_sequencer: phase-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_game_flow_sequencer;
    localparam int CLK    = 10;
    localparam int T_SEC  = 2;
    localparam int C_SEC  = 1;
    localparam int S_SEC  = 3;
    localparam int NR     = 2;
    localparam int TW     = 16;

    localparam int P_START = 0, P_IDLE = 1, P_CD = 2, P_PLAY = 3, P_PAUSE = 4, P_GO = 5;

    logic clock = 1'b0;
    logic reset_n;

    game_flow_sequencer_if #(.NUM_ROUNDS(NR), .TIMER_W(TW)) bus ();

    game_flow_sequencer #(
        .CLK_HZ(CLK), .TITLE_SEC(T_SEC), .COUNTDOWN_SEC(C_SEC),
        .SONG_SEC(S_SEC), .NUM_ROUNDS(NR), .TIMER_W(TW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_total  = 0;
    int n_passed = 0;
    bit cmp_en   = 1'b0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic int sec_of(input int p);
        case (p)
            P_START: return T_SEC;
            P_CD:    return C_SEC;
            P_PLAY:  return S_SEC;
            default: return 0;
        endcase
    endfunction

    function automatic bit timed(input int p);
        return (p == P_START) || (p == P_CD) || (p == P_PLAY);
    endfunction

    // Phase-level model: elapsed cycles per phase, seconds derived by division
    int       m_phase = P_START, m_saved = P_START, m_elapsed = 0, m_round = 0, m_np;
    bit       m_won = 0, m_tick = 0, m_changed = 0, m_sp, m_pp, m_to;
    bit [2:0] m_hs = 3'b111, m_hp = 3'b111;   // sampled pin history, [0] newest

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = P_START; m_saved = P_START; m_elapsed = 0; m_round = 0;
            m_won = 0; m_tick = 0; m_changed = 0; m_hs = 3'b111; m_hp = 3'b111;
        end else begin
            m_sp = !m_hs[1] && m_hs[2];
            m_pp = !m_hp[1] && m_hp[2];
            m_hs = {m_hs[1:0], bus.start_n};
            m_hp = {m_hp[1:0], bus.pause_n};
            m_to = timed(m_phase) && (m_elapsed == CLK * sec_of(m_phase) - 1);
            m_np = m_phase;
            case (m_phase)
                P_START: if (m_to || m_sp) m_np = P_IDLE; else if (m_pp) m_np = P_PAUSE;
                P_IDLE:  if (m_sp) begin m_np = P_CD; m_round = 0; m_won = 0; end
                P_CD:    if (m_to) m_np = P_PLAY; else if (m_pp) m_np = P_PAUSE;
                P_PLAY: begin
                    if (m_to) begin
                        if (!bus.round_pass) begin m_np = P_GO; m_won = 0; end
                        else if (m_round < NR - 1) begin m_np = P_CD; m_round++; end
                        else begin m_np = P_GO; m_won = 1; end
                    end else if (m_pp) m_np = P_PAUSE;
                end
                P_PAUSE: if (m_pp) m_np = m_saved;
                default: if (m_sp) m_np = P_IDLE;
            endcase
            m_tick = 0;
            if (m_np != m_phase && m_np != P_PAUSE && m_phase != P_PAUSE) m_elapsed = 0;
            else if (timed(m_phase)) begin
                m_elapsed++;
                m_tick = (m_elapsed % CLK == 0);
            end
            if (m_np == P_PAUSE && m_phase != P_PAUSE) m_saved = m_phase;
            m_changed = (m_np != m_phase);
            m_phase   = m_np;
        end
    end

    int       e_q, e_sec;
    bit [8:0] e_en, a_en;

    always @(negedge clock) begin
        if (cmp_en) begin
            e_q   = (m_phase == P_PAUSE) ? m_saved : m_phase;
            e_sec = timed(e_q) ? sec_of(e_q) - m_elapsed / CLK : 0;
            e_en  = {m_phase == P_START || (m_phase == P_PAUSE && m_saved == P_START),
                     m_phase == P_IDLE, m_phase == P_START,
                     m_phase == P_CD || (m_phase == P_PAUSE && m_saved == P_CD),
                     m_phase == P_CD, m_phase == P_PLAY, m_phase == P_PLAY,
                     m_phase == P_PAUSE, m_phase == P_GO};
            a_en  = {bus.enable_title_screen, bus.enable_idle_screen, bus.enable_title_audio,
                     bus.enable_countdown_screen, bus.enable_countdown_audio, bus.enable_song,
                     bus.game_active, bus.show_pause_screen, bus.show_game_over};
            check("model_state",   longint'(bus.state), m_phase);
            check("model_enables", longint'(a_en), longint'(e_en));
            check("model_round",   longint'(bus.round_idx), m_round);
            check("model_won",     longint'(bus.game_won), longint'(m_won));
            check("model_cycles",  longint'(bus.phase_cycles), m_elapsed);
            check("model_secrem",  longint'(bus.sec_remaining), e_sec);
            check("model_tick",    longint'(bus.sec_tick), longint'(m_tick));
            check("model_changed", longint'(bus.state_changed), longint'(m_changed));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic count_state(input int s, output int n, output int tick_pc);
        n = 0;
        tick_pc = -1;
        while (int'(bus.state) == s && n < 200) begin
            if (bus.sec_tick) tick_pc = int'(bus.phase_cycles);
            n++;
            step(1);
        end
    endtask

    task automatic wait_for(input int s, input int pc);
        int n = 0;
        while (!(int'(bus.state) == s && int'(bus.phase_cycles) == pc) && n < 300) begin
            n++;
            step(1);
        end
        check("wait_for_bound", longint'(n < 300), 1);
    endtask

    task automatic press(input bit is_start);
        if (is_start) bus.start_n = 1'b0; else bus.pause_n = 1'b0;
        step(3);
        bus.start_n = 1'b1;
        bus.pause_n = 1'b1;
    endtask

    int n, tpc;

    initial begin
        reset_n = 1'b0;
        bus.start_n = 1'b1;
        bus.pause_n = 1'b1;
        bus.round_pass = 1'b0;
        step(2);
        cmp_en = 1'b1;
        check("rst_state", longint'(bus.state), 0);
        check("rst_cycles", longint'(bus.phase_cycles), 0);
        check("rst_secrem", longint'(bus.sec_remaining), 2);
        check("rst_title", longint'({bus.enable_title_screen, bus.enable_title_audio}), 3);

        // Startup runs its full two seconds
        reset_n = 1'b1;
        count_state(P_START, n, tpc);
        check("startup_len", n, 20);
        check("startup_tick_pc", tpc, 10);
        check("idle_entry", longint'(bus.state), P_IDLE);
        check("idle_changed", longint'(bus.state_changed), 1);
        step(1);
        check("idle_changed_clr", longint'(bus.state_changed), 0);

        // Start held low for 50 cycles: one press, then round 0 countdown and play
        bus.round_pass = 1'b1;
        bus.start_n = 1'b0;
        step(3);
        check("cd_entry", longint'(bus.state), P_CD);
        check("cd_round0", longint'(bus.round_idx), 0);
        count_state(P_CD, n, tpc);
        check("cd_len", n, 10);
        check("play_entry", longint'(bus.state), P_PLAY);
        count_state(P_PLAY, n, tpc);
        check("play_len", n, 30);
        check("round1_cd", longint'(bus.state), P_CD);
        check("round1_idx", longint'(bus.round_idx), 1);
        step(7);
        bus.start_n = 1'b1;

        // Pause during round 1 at phase_cycles 12, hold 40 cycles, resume
        wait_for(P_PLAY, 9);
        bus.pause_n = 1'b0;
        step(3);
        bus.pause_n = 1'b1;
        check("pause_entry", longint'(bus.state), P_PAUSE);
        check("pause_cycles", longint'(bus.phase_cycles), 12);
        check("pause_secrem", longint'(bus.sec_remaining), 2);
        check("pause_song", longint'({bus.enable_song, bus.game_active}), 0);
        step(20);
        check("pause_mid_cycles", longint'(bus.phase_cycles), 12);
        check("pause_mid_secrem", longint'(bus.sec_remaining), 2);
        step(17);
        press(1'b0);
        check("resume_state", longint'(bus.state), P_PLAY);
        check("resume_cycles", longint'(bus.phase_cycles), 12);
        count_state(P_PLAY, n, tpc);
        check("resume_len", n, 18);
        check("won_state", longint'(bus.state), P_GO);
        check("won_flag", longint'(bus.game_won), 1);

        // Pause ignored in GAMEOVER and IDLE
        press(1'b0);
        check("go_pause_ignored", longint'(bus.state), P_GO);
        step(2);
        press(1'b1);
        check("go_to_idle", longint'(bus.state), P_IDLE);
        press(1'b0);
        check("idle_pause_ignored", longint'(bus.state), P_IDLE);
        step(2);
        press(1'b1);
        check("cd_again", longint'(bus.state), P_CD);
        check("won_cleared", longint'(bus.game_won), 0);

        // Pause press on the countdown timeout cycle is discarded
        wait_for(P_CD, 7);
        press(1'b0);
        check("timeout_wins", longint'(bus.state), P_PLAY);
        check("timeout_wins_pc", longint'(bus.phase_cycles), 0);
        step(5);
        check("press_discarded", longint'(bus.state), P_PLAY);
        bus.round_pass = 1'b0;
        count_state(P_PLAY, n, tpc);
        check("fail_play_len", n, 25);
        check("lost_state", longint'(bus.state), P_GO);
        check("lost_flag", longint'(bus.game_won), 0);
        check("lost_round", longint'(bus.round_idx), 0);

        // Asynchronous reset while paused
        step(2);
        press(1'b1);
        step(2);
        press(1'b1);
        step(2);
        press(1'b0);
        check("pause_before_rst", longint'(bus.state), P_PAUSE);
        step(4);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", longint'(bus.state), P_START);
        check("arst_cycles", longint'(bus.phase_cycles), 0);
        check("arst_secrem", longint'(bus.sec_remaining), 2);
        check("arst_pause_scr", longint'(bus.show_pause_screen), 0);
        check("arst_title", longint'(bus.enable_title_screen), 1);
        @(negedge clock);
        reset_n = 1'b1;
        count_state(P_START, n, tpc);
        check("restart_len", n, 20);
        check("restart_idle", longint'(bus.state), P_IDLE);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
